// File: rtl/png_pkg.sv
// png_pkg: shared constants and state encoding for the PNG chunk wrapper.
package png_pkg;
    localparam logic [31:0] PNG_CRC_PRESET   = 32'hFFFF_FFFF;
    localparam logic [31:0] PNG_CRC_POLY_REF = 32'hEDB8_8320;
    localparam logic [31:0] PNG_TYP_IHDR     = 32'h4948_4452;
    localparam logic [31:0] PNG_TYP_IDAT     = 32'h4944_4154;
    localparam logic [31:0] PNG_TYP_IEND     = 32'h4945_4E44;
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_TYP, S_DAT, S_CRC} chunk_state_e;
endpackage

// File: rtl/png_crc32_upd.sv
// png_crc32_upd: one-byte update of the reflected PNG CRC-32, LSB first.
module png_crc32_upd
    import png_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] crc_o
);
    always_comb begin
        crc_o = crc_i ^ {24'h0, byte_i};
        for (int i = 0; i < 8; i++)
            crc_o = crc_o[0] ? (crc_o >> 1) ^ PNG_CRC_POLY_REF : crc_o >> 1;
    end
endmodule

// File: rtl/png_chunk_wrap.sv
// png_chunk_wrap: frames a payload byte stream as LENGTH | TYPE | DATA | CRC.
module png_chunk_wrap
    import png_pkg::*;
#(
    parameter int LEN_WD = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [LEN_WD-1:0] len_i,
    input  logic [31:0]       typ_i,
    input  logic              val_i,
    input  logic [7:0]        dat_i,
    input  logic              lst_i,
    output logic              rdy_o,
    output logic              val_o,
    output logic [7:0]        dat_o,
    output logic              lst_o,
    input  logic              rdy_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    chunk_state_e      state, state_nx;
    logic [1:0]        idx;
    logic [LEN_WD-1:0] cnt, len_q;
    logic [31:0]       typ_q, crc, crc_nx, len32, crc_out;
    logic              xfer, fld_end, dat_last;

    assign len32    = 32'(len_q);
    assign crc_out  = ~crc;
    assign xfer     = val_o & rdy_i;
    assign fld_end  = xfer && idx == 2'd3;
    assign dat_last = cnt == len_q - LEN_WD'(1);
    assign busy_o   = state != S_IDLE;

    // dat_o doubles as the CRC input byte: it is the TYPE byte in TYP and the payload in DAT
    png_crc32_upd u_crc (.crc_i(crc), .byte_i(dat_o), .crc_o(crc_nx));

    always_comb begin
        val_o = 1'b0;
        rdy_o = 1'b0;
        dat_o = 8'h00;
        lst_o = 1'b0;
        case (state)
            S_LEN: begin
                val_o = 1'b1;
                dat_o = len32[{~idx, 3'b000} +: 8];
            end
            S_TYP: begin
                val_o = 1'b1;
                dat_o = typ_q[{~idx, 3'b000} +: 8];
            end
            S_DAT: begin
                val_o = val_i;
                rdy_o = rdy_i;
                dat_o = dat_i;
            end
            S_CRC: begin
                val_o = 1'b1;
                dat_o = crc_out[{~idx, 3'b000} +: 8];
                lst_o = idx == 2'd3;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = start_i ? S_LEN : S_IDLE;
            S_LEN:   state_nx = fld_end ? S_TYP : S_LEN;
            S_TYP:   state_nx = fld_end ? (len_q == '0 ? S_CRC : S_DAT) : S_TYP;
            S_DAT:   state_nx = xfer && dat_last ? S_CRC : S_DAT;
            S_CRC:   state_nx = fld_end ? S_IDLE : S_CRC;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            idx    <= 2'd0;
            cnt    <= '0;
            len_q  <= '0;
            typ_q  <= 32'h0;
            crc    <= PNG_CRC_PRESET;
            done_o <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            state  <= state_nx;
            done_o <= state == S_CRC && fld_end;
            if (state == S_IDLE && start_i) begin
                len_q <= len_i;
                typ_q <= typ_i;
                crc   <= PNG_CRC_PRESET;
                err_o <= 1'b0;
                idx   <= 2'd0;
                cnt   <= '0;
            end
            if (xfer && state != S_DAT)
                idx <= idx + 2'd1;
            if (xfer && (state == S_TYP || state == S_DAT))
                crc <= crc_nx;
            // lst_i is only cross-checked; framing always follows the latched length
            if (xfer && state == S_DAT) begin
                cnt <= cnt + LEN_WD'(1);
                if (lst_i != dat_last)
                    err_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_png_chunk_wrap.sv
// tb_png_chunk_wrap: randomized self-checking bench against a byte-queue chunk model.
module tb_png_chunk_wrap;
    logic        clk = 1'b0, rstn = 1'b0, start_i = 1'b0, val_i = 1'b0, lst_i = 1'b0, rdy_i = 1'b0;
    logic [31:0] len_i = 32'h0, typ_i = 32'h0;
    logic [7:0]  dat_i = 8'h0;
    logic        rdy_o, val_o, lst_o, busy_o, done_o, err_o;
    logic [7:0]  dat_o;

    int          nchk = 0, nfail = 0;
    logic [7:0]  obs_b[$], exp_b[$], pay[$];
    bit          obs_l[$];
    int          rdy_cnt = 0, stab_err = 0, mcyc = 0, lst_cyc = -10, done_cyc = -20;
    bit          prev_stall = 0;
    logic [7:0]  prev_dat = 8'h0;
    logic [31:0] crc_tab[256];
    logic [7:0]  iend_ref[12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h49, 8'h45, 8'h4E, 8'h44,
                                  8'hAE, 8'h42, 8'h60, 8'h82};
    logic [7:0]  crc1234[4] = '{8'hCB, 8'hF4, 8'h39, 8'h26};

    png_chunk_wrap #(.LEN_WD(32)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .len_i(len_i), .typ_i(typ_i),
        .val_i(val_i), .dat_i(dat_i), .lst_i(lst_i), .rdy_o(rdy_o), .val_o(val_o),
        .dat_o(dat_o), .lst_o(lst_o), .rdy_i(rdy_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    // output collector: records every transferred byte and flags any change while stalled
    always @(negedge clk) begin
        mcyc++;
        if (!rstn) prev_stall = 0;
        else begin
            if (prev_stall && (!val_o || dat_o !== prev_dat)) stab_err++;
            if (val_o && rdy_i) begin
                obs_b.push_back(dat_o);
                obs_l.push_back(lst_o);
                if (lst_o) lst_cyc = mcyc;
            end
            if (rdy_o) rdy_cnt++;
            if (done_o) done_cyc = mcyc;
            prev_stall = val_o && !rdy_i;
            prev_dat = dat_o;
        end
    end

    task automatic fill_rand(input int n);
        pay = {};
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    // drives one chunk from the current time; returns shortly after the done_o cycle's negedge
    task automatic run_chunk(input logic [31:0] len, input logic [31:0] typ, input int bad_pos,
                             input bit rnd, input bit extra_start, input string nm);
        int pos, cyc, nbad, nlst;
        bit done_seen, hold, exp_err;
        logic [31:0] c;
        logic [7:0] b;
        exp_b = {};
        for (int i = 3; i >= 0; i--) exp_b.push_back(len[8*i +: 8]);
        c = 32'hFFFF_FFFF;
        for (int i = 3; i >= 0; i--) begin
            b = typ[8*i +: 8];
            exp_b.push_back(b);
            c = crc_tab[c[7:0] ^ b] ^ (c >> 8);
        end
        foreach (pay[i]) begin
            exp_b.push_back(pay[i]);
            c = crc_tab[c[7:0] ^ pay[i]] ^ (c >> 8);
        end
        c = ~c;
        for (int i = 3; i >= 0; i--) exp_b.push_back(c[8*i +: 8]);
        exp_err = bad_pos >= 0 && bad_pos != int'(len) - 1;
        obs_b = {}; obs_l = {}; rdy_cnt = 0; stab_err = 0;
        start_i = 1'b1; len_i = len; typ_i = typ; val_i = 1'b0; lst_i = 1'b0; rdy_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        pos = 0; cyc = 0; done_seen = 0; hold = 0;
        while (!done_seen && cyc < 3000) begin
            rdy_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!hold) begin
                val_i = pos < int'(len) && (!rnd || $urandom_range(0, 3) != 0);
                dat_i = pos < int'(len) ? pay[pos] : 8'h00;
                lst_i = val_i && (bad_pos >= 0 ? pos == bad_pos : pos == int'(len) - 1);
            end
            start_i = extra_start && pos == 1;
            len_i = start_i ? 32'd7 : len;
            typ_i = start_i ? ~typ : typ;
            @(negedge clk);
            if (cyc == 0) begin
                nchk++;
                if ({val_o, busy_o, err_o, dat_o} !== {1'b1, 1'b1, 1'b0, len[31:24]}) begin
                    nfail++;
                    $display("FAIL %s first_len_byte: val/busy/err/dat=%b%b%b %h required 110 %h",
                             nm, val_o, busy_o, err_o, dat_o, len[31:24]);
                end
            end
            hold = val_i && !rdy_o;
            if (val_i && rdy_o) pos++;
            if (done_o) done_seen = 1;
            else begin @(posedge clk); #1; end
            cyc++;
        end
        start_i = 1'b0; val_i = 1'b0; lst_i = 1'b0; len_i = len; typ_i = typ;
        #1;
        nchk++;
        if (!done_seen) begin
            nfail++;
            $display("FAIL %s timeout: done_o not seen in %0d cycles", nm, cyc);
        end
        nbad = obs_b.size() == exp_b.size() ? 0 : 1;
        for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++)
            if (obs_b[i] !== exp_b[i]) begin
                if (nbad == 0)
                    $display("FAIL %s byte[%0d]: got %h required %h", nm, i, obs_b[i], exp_b[i]);
                nbad++;
            end
        nchk++;
        if (nbad != 0) begin
            nfail++;
            $display("FAIL %s stream: %0d bad, got %0d bytes required %0d", nm, nbad, obs_b.size(), exp_b.size());
        end
        nlst = 0;
        foreach (obs_l[i]) nlst += int'(obs_l[i]);
        nchk++;
        if (nlst != 1 || obs_l.size() == 0 || !obs_l[obs_l.size()-1]) begin
            nfail++;
            $display("FAIL %s lst_o: got %0d markers, required 1 on final byte", nm, nlst);
        end
        nchk++;
        if (done_cyc != lst_cyc + 1) begin
            nfail++;
            $display("FAIL %s done_o timing: got cycle %0d required %0d", nm, done_cyc, lst_cyc + 1);
        end
        nchk++;
        if (err_o !== exp_err) begin
            nfail++;
            $display("FAIL %s err_o: got %b required %b", nm, err_o, exp_err);
        end
        nchk++;
        if (busy_o !== 1'b0 || stab_err != 0) begin
            nfail++;
            $display("FAIL %s idle/stability: busy_o=%b stall changes=%0d required 0/0", nm, busy_o, stab_err);
        end
        if (!rnd) begin
            nchk++;
            if (rdy_cnt != int'(len)) begin
                nfail++;
                $display("FAIL %s rdy_o cycles: got %0d required %0d", nm, rdy_cnt, len);
            end
        end
    endtask

    task automatic test_reset();
        #3;
        nchk++;
        if ({val_o, rdy_o, lst_o, busy_o, done_o, err_o, dat_o} !== 14'h0) begin
            nfail++;
            $display("FAIL reset: outputs %b required all 0", {val_o, rdy_o, lst_o, busy_o, done_o, err_o, dat_o});
        end
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_iend();
        int nbad;
        pay = {};
        run_chunk(32'd0, 32'h4945_4E44, -1, 0, 0, "iend");
        nbad = obs_b.size() == 12 ? 0 : 1;
        for (int i = 0; i < 12 && i < obs_b.size(); i++) if (obs_b[i] !== iend_ref[i]) nbad++;
        nchk++;
        if (nbad != 0) begin
            nfail++;
            $display("FAIL iend_const: %0d bytes differ from 0000000049454E44AE426082", nbad);
        end
    endtask

    task automatic test_1234(input bit rnd, input string nm);
        int nbad, n;
        pay = {8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_chunk(32'd5, 32'h3132_3334, -1, rnd, 0, nm);
        n = obs_b.size();
        nbad = n == 17 ? 0 : 1;
        for (int i = 0; i < 4 && n >= 4; i++) if (obs_b[n-4+i] !== crc1234[i]) nbad++;
        nchk++;
        if (nbad != 0) begin
            nfail++;
            $display("FAIL %s crc_const: %0d bytes differ from CBF43926 (got %0d bytes)", nm, nbad, n);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            fill_rand($urandom_range(0, 20));
            run_chunk(32'(pay.size()), $urandom, -1, 1, 0, "random");
        end
    endtask

    task automatic test_err();
        fill_rand(3);
        run_chunk(32'd3, 32'h4944_4154, 1, 0, 0, "err_early_lst");
        fill_rand(4);
        run_chunk(32'd4, 32'h4944_4154, -1, 0, 0, "err_cleared");
        fill_rand(2);
        run_chunk(32'd2, 32'h4944_4154, 5, 0, 0, "err_missing_lst");
    endtask

    task automatic test_back_to_back();
        fill_rand(6);
        run_chunk(32'd6, 32'h4948_4452, -1, 0, 1, "b2b_first");
        fill_rand(3);
        run_chunk(32'd3, 32'h4944_4154, -1, 0, 0, "b2b_second");
    endtask

    task automatic test_async_reset();
        int cyc;
        pay = {};
        start_i = 1'b1; len_i = 32'd0; typ_i = 32'h4945_4E44; rdy_i = 1'b1; val_i = 1'b0;
        obs_b = {}; obs_l = {};
        @(posedge clk); #1 start_i = 1'b0;
        cyc = 0;
        while (obs_b.size() < 6 && cyc < 50) begin
            @(negedge clk); #1;
            cyc++;
        end
        rstn = 1'b0;
        #1;
        nchk++;
        if (cyc >= 50 || {val_o, rdy_o, lst_o, busy_o, done_o, err_o, dat_o} !== 14'h0) begin
            nfail++;
            $display("FAIL async_reset: outputs %b after %0d cycles, required all 0",
                     {val_o, rdy_o, lst_o, busy_o, done_o, err_o, dat_o}, cyc);
        end
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
        test_iend();
    endtask

    initial begin
        for (int n = 0; n < 256; n++) begin
            crc_tab[n] = 32'(n);
            for (int k = 0; k < 8; k++)
                crc_tab[n] = crc_tab[n][0] ? (crc_tab[n] >> 1) ^ 32'hEDB8_8320 : crc_tab[n] >> 1;
        end
        test_reset();
        test_iend();
        test_1234(0, "crc_1234");
        test_1234(1, "crc_1234_stall");
        test_random();
        test_err();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
